// File: rtl/drive_loader_pkg.sv
// Shared types for the drive-circuit configuration loader: write targets, FSM states
// and the FIFO entry layout (default widths).
package drive_loader_pkg;

    typedef enum logic [2:0] {
        TGT_INST_LIST  = 3'd0,
        TGT_INST_TABLE = 3'd1,
        TGT_ENVE       = 3'd2,
        TGT_CALI       = 3'd3,
        TGT_Z_CORR     = 3'd4,
        TGT_SIN_LUT    = 3'd5,
        TGT_COS_LUT    = 3'd6,
        TGT_NCO_FTW    = 3'd7
    } target_e;

    typedef enum logic [1:0] {
        FSM_LOAD  = 2'd0,
        FSM_ARMED = 2'd1,
        FSM_START = 2'd2,
        FSM_RUN   = 2'd3
    } fsm_state_e;

    localparam int unsigned DL_SEL_WIDTH  = 8;
    localparam int unsigned DL_ADDR_WIDTH = 10;
    localparam int unsigned DL_DATA_WIDTH = 32;

    // Layout of a FIFO entry, MSB first; the top packs the same order at any width.
    typedef struct packed {
        logic                     last;
        target_e                  target;
        logic [DL_SEL_WIDTH-1:0]  sel;
        logic [DL_ADDR_WIDTH-1:0] addr;
        logic [DL_DATA_WIDTH-1:0] data;
    } entry_t;

    function automatic int unsigned entry_width(int unsigned sel_w, int unsigned addr_w,
                                                int unsigned data_w);
        return 1 + 3 + sel_w + addr_w + data_w;
    endfunction

endpackage

// File: rtl/drive_loader_fifo.sv
// Synchronous command FIFO with occupancy count, registered not-full flag and empty flag.
module drive_loader_fifo
    import drive_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ready,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic             do_push, do_pop;

    always_comb begin
        // A full FIFO refuses a push even when it pops in the same cycle.
        do_push  = push & ready_q;
        do_pop   = pop & (count_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
        ready_d = (count_d != DepthCnt);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign ready = ready_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/drive_loader_scheduler.sv
// Host-side drive-circuit configuration sequencer: buffers writes, drains them while the
// drive pipeline is idle, then triggers it. Option: DRIVE_LOADER_AUTO_TRIGGER_EN.
module drive_loader_scheduler
    import drive_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_target,
    input  logic [SEL_WIDTH-1:0]  cmd_sel,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_last,
    input  logic                  run_req,
    input  logic                  drive_active,
    output logic                  trigger,
    output logic [SEL_WIDTH-1:0]  bank_wr_sel,
    output logic [SEL_WIDTH-1:0]  inst_table_wr_sel,
    output logic [SEL_WIDTH-1:0]  nco_ftw_wr_en,
    output logic                  inst_list_wr_en,
    output logic                  inst_table_wr_en,
    output logic                  enve_memory_wr_en,
    output logic                  cali_memory_wr_en,
    output logic                  z_corr_memory_wr_en,
    output logic                  sin_lut_wr_en,
    output logic                  cos_lut_wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [1:0]            state_out
);

    localparam logic [1:0] ST_LOAD  = FSM_LOAD;
    localparam logic [1:0] ST_ARMED = FSM_ARMED;
    localparam logic [1:0] ST_START = FSM_START;
    localparam logic [1:0] ST_RUN   = FSM_RUN;

    localparam int unsigned EntryW  = entry_width(SEL_WIDTH, ADDR_WIDTH, DATA_WIDTH);
    localparam int unsigned OffAddr = DATA_WIDTH;
    localparam int unsigned OffSel  = OffAddr + ADDR_WIDTH;
    localparam int unsigned OffTgt  = OffSel + SEL_WIDTH;
    localparam int unsigned OffLast = OffTgt + 3;

    logic [EntryW-1:0]         push_entry, pop_entry;
    logic [$clog2(FIFO_DEPTH):0] unused_count;
    logic                      fifo_ready, fifo_empty, pop_en, go;
    target_e                   pop_target;
    logic [SEL_WIDTH-1:0]      pop_sel;
    logic                      pop_last, pop_has_sel;

    logic [1:0]            state_q, state_d;
    logic                  trigger_q, trigger_d;
    logic [6:0]            mem_wr_en_q, mem_wr_en_d;
    logic [SEL_WIDTH-1:0]  bank_sel_q, bank_sel_d;
    logic [SEL_WIDTH-1:0]  itab_sel_q, itab_sel_d;
    logic [SEL_WIDTH-1:0]  nco_en_q, nco_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    assign push_entry = {cmd_last, cmd_target, cmd_sel, cmd_addr, cmd_data};
    assign pop_en     = (state_q == ST_LOAD) & ~fifo_empty;

    drive_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EntryW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (push_entry),
        .pop   (pop_en),
        .rdata (pop_entry),
        .count (unused_count),
        .ready (fifo_ready),
        .empty (fifo_empty)
    );

    assign pop_target  = target_e'(pop_entry[OffLast-1:OffTgt]);
    assign pop_sel     = pop_entry[OffTgt-1:OffSel];
    assign pop_last    = pop_entry[OffLast];
    assign pop_has_sel = |pop_sel;

`ifdef DRIVE_LOADER_AUTO_TRIGGER_EN
    logic unused_run_req;
    assign unused_run_req = run_req;
    assign go = 1'b1;
`else
    assign go = run_req;
`endif

    always_comb begin
        state_d     = state_q;
        trigger_d   = 1'b0;
        mem_wr_en_d = '0;
        bank_sel_d  = '0;
        itab_sel_d  = '0;
        nco_en_d    = '0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            ST_LOAD: begin
                if (pop_en) begin
                    // An all-zero select is a silent no-op that still closes a batch.
                    if (pop_has_sel) begin
                        wr_addr_d = pop_entry[OffSel-1:OffAddr];
                        wr_data_d = pop_entry[DATA_WIDTH-1:0];
                    end
                    unique case (pop_target)
                        TGT_INST_LIST:  begin mem_wr_en_d[0] = pop_has_sel; bank_sel_d = pop_sel; end
                        TGT_INST_TABLE: begin
                            mem_wr_en_d[1] = pop_has_sel;
                            bank_sel_d     = pop_sel;
                            itab_sel_d     = pop_sel;
                        end
                        TGT_ENVE:       begin mem_wr_en_d[2] = pop_has_sel; bank_sel_d = pop_sel; end
                        TGT_CALI:       begin mem_wr_en_d[3] = pop_has_sel; bank_sel_d = pop_sel; end
                        TGT_Z_CORR:     begin mem_wr_en_d[4] = pop_has_sel; bank_sel_d = pop_sel; end
                        TGT_SIN_LUT:    begin mem_wr_en_d[5] = pop_has_sel; bank_sel_d = pop_sel; end
                        TGT_COS_LUT:    begin mem_wr_en_d[6] = pop_has_sel; bank_sel_d = pop_sel; end
                        TGT_NCO_FTW:    nco_en_d = pop_sel;
                        default:        ;
                    endcase
                    if (pop_last) begin
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (go) begin
                    trigger_d = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: if (drive_active) state_d = ST_RUN;
            ST_RUN:   if (!drive_active) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            trigger_q   <= 1'b0;
            mem_wr_en_q <= '0;
            bank_sel_q  <= '0;
            itab_sel_q  <= '0;
            nco_en_q    <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            trigger_q   <= trigger_d;
            mem_wr_en_q <= mem_wr_en_d;
            bank_sel_q  <= bank_sel_d;
            itab_sel_q  <= itab_sel_d;
            nco_en_q    <= nco_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign cmd_ready           = fifo_ready;
    assign trigger             = trigger_q;
    assign bank_wr_sel         = bank_sel_q;
    assign inst_table_wr_sel   = itab_sel_q;
    assign nco_ftw_wr_en       = nco_en_q;
    assign inst_list_wr_en     = mem_wr_en_q[0];
    assign inst_table_wr_en    = mem_wr_en_q[1];
    assign enve_memory_wr_en   = mem_wr_en_q[2];
    assign cali_memory_wr_en   = mem_wr_en_q[3];
    assign z_corr_memory_wr_en = mem_wr_en_q[4];
    assign sin_lut_wr_en       = mem_wr_en_q[5];
    assign cos_lut_wr_en       = mem_wr_en_q[6];
    assign wr_addr             = wr_addr_q;
    assign wr_data             = wr_data_q;
    assign state_out           = state_q;

endmodule

// File: tb/tb_drive_loader_scheduler.sv
// Self-checking bench for drive_loader_scheduler: directed scenarios plus random traffic,
// compared each cycle against a queue-based behavioural model.
module tb_drive_loader_scheduler;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int SW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_target = '0;
    logic [SW-1:0] cmd_sel = '0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;
    logic          cmd_last = 1'b0;
    logic          run_req = 1'b0;
    logic          drive_active = 1'b0;
    logic          trigger;
    logic [SW-1:0] bank_wr_sel, inst_table_wr_sel, nco_ftw_wr_en;
    logic          inst_list_wr_en, inst_table_wr_en, enve_memory_wr_en, cali_memory_wr_en;
    logic          z_corr_memory_wr_en, sin_lut_wr_en, cos_lut_wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    state_out;

    always #5 clk = ~clk;

    drive_loader_scheduler dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_target          (cmd_target),
        .cmd_sel             (cmd_sel),
        .cmd_addr            (cmd_addr),
        .cmd_data            (cmd_data),
        .cmd_last            (cmd_last),
        .run_req             (run_req),
        .drive_active        (drive_active),
        .trigger             (trigger),
        .bank_wr_sel         (bank_wr_sel),
        .inst_table_wr_sel   (inst_table_wr_sel),
        .nco_ftw_wr_en       (nco_ftw_wr_en),
        .inst_list_wr_en     (inst_list_wr_en),
        .inst_table_wr_en    (inst_table_wr_en),
        .enve_memory_wr_en   (enve_memory_wr_en),
        .cali_memory_wr_en   (cali_memory_wr_en),
        .z_corr_memory_wr_en (z_corr_memory_wr_en),
        .sin_lut_wr_en       (sin_lut_wr_en),
        .cos_lut_wr_en       (cos_lut_wr_en),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .state_out           (state_out)
    );

    typedef struct {
        bit          last;
        int          tgt;
        bit [SW-1:0] sel;
        bit [AW-1:0] addr;
        bit [DW-1:0] data;
    } cmd_t;

    // Reference model: pending host writes, batch phase and the expected registered outputs.
    cmd_t        q[$];
    int          phase = 0;
    bit [6:0]    e_en = '0;
    bit [SW-1:0] e_bank = '0, e_itab = '0, e_nco = '0;
    bit [AW-1:0] e_addr = '0;
    bit [DW-1:0] e_data = '0;
    bit          e_trig = 1'b0;
    bit          e_ready = 1'b1;

    int errors = 0;
    int checks = 0;

`ifdef DRIVE_LOADER_AUTO_TRIGGER_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {cos_lut_wr_en, sin_lut_wr_en, z_corr_memory_wr_en, cali_memory_wr_en,
                enve_memory_wr_en, inst_table_wr_en, inst_list_wr_en};
    endfunction

    // Advance the model by one rising edge using the inputs as they stand before it.
    task automatic model_edge();
        cmd_t c;
        bit   accept;
        accept = cmd_valid && e_ready;
        e_en = '0; e_bank = '0; e_itab = '0; e_nco = '0; e_trig = 1'b0;
        if (phase == 0) begin
            if (q.size() > 0) begin
                c = q.pop_front();
                if (c.sel != 0) begin
                    e_addr = c.addr;
                    e_data = c.data;
                    if (c.tgt == 7) begin
                        e_nco = c.sel;
                    end else begin
                        e_en[c.tgt] = 1'b1;
                        e_bank      = c.sel;
                        if (c.tgt == 1) e_itab = c.sel;
                    end
                end
                if (c.last) phase = 1;
            end
        end else if (phase == 1) begin
            if (AUTO || run_req) begin
                e_trig = 1'b1;
                phase  = 2;
            end
        end else if (phase == 2) begin
            if (drive_active) phase = 3;
        end else begin
            if (!drive_active) phase = 0;
        end
        if (accept) begin
            c.last = cmd_last; c.tgt = int'(cmd_target); c.sel = cmd_sel;
            c.addr = cmd_addr; c.data = cmd_data;
            q.push_back(c);
        end
        e_ready = (q.size() < DEPTH);
    endtask

    task automatic check_all();
        chk("strobes", 64'(strobes()), 64'(e_en));
        chk("bank_wr_sel", 64'(bank_wr_sel), 64'(e_bank));
        chk("inst_table_wr_sel", 64'(inst_table_wr_sel), 64'(e_itab));
        chk("nco_ftw_wr_en", 64'(nco_ftw_wr_en), 64'(e_nco));
        chk("wr_addr", 64'(wr_addr), 64'(e_addr));
        chk("wr_data", 64'(wr_data), 64'(e_data));
        chk("trigger", 64'(trigger), 64'(e_trig));
        chk("state", 64'(state_out), 64'(phase));
        chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_cmd(input int tgt, input int sel, input int addr, input int data,
                           input bit last);
        cmd_valid  = 1'b1;
        cmd_target = 3'(tgt);
        cmd_sel    = SW'(sel);
        cmd_addr   = AW'(addr);
        cmd_data   = DW'(data);
        cmd_last   = last;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobes"}, 64'(strobes()), 64'd0);
        chk({tag, "_bank"}, 64'(bank_wr_sel), 64'd0);
        chk({tag, "_itab"}, 64'(inst_table_wr_sel), 64'd0);
        chk({tag, "_nco"}, 64'(nco_ftw_wr_en), 64'd0);
        chk({tag, "_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, "_data"}, 64'(wr_data), 64'd0);
        chk({tag, "_trigger"}, 64'(trigger), 64'd0);
        chk({tag, "_state"}, 64'(state_out), 64'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_all_zero("rst");
        rst = 1'b1;
        step();
        chk("rst_ready", 64'(cmd_ready), 64'd1);

        // Single enve write closing a batch
        set_cmd(2, 8'h01, 10'h005, 32'hABCD, 1'b1);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t1_enve", 64'(enve_memory_wr_en), 64'd1);
        chk("t1_bank", 64'(bank_wr_sel), 64'h01);
        chk("t1_addr", 64'(wr_addr), 64'h5);
        chk("t1_data", 64'(wr_data), 64'hABCD);

        // Trigger handshake, then park in RUN
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step();
        drive_active = 1'b1;
        step();
        chk("in_run", 64'(state_out), 64'd3);

        // Ten back-to-back writes against an 8-deep FIFO while RUN blocks draining
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      set_cmd(7, 8'h04, i, 32'h1000 + i, 1'b0);
            else if (i == 1) set_cmd(1, 8'h80, i, 32'h1000 + i, 1'b0);
            else             set_cmd(i % 7, 1 << (i % 8), i * 3, 32'h1000 + i, i == 7);
            step();
            chk("bp_ready", 64'(cmd_ready), 64'(i < 7));
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_no_strobe", 64'({strobes(), nco_ftw_wr_en}), 64'd0);
        end
        drive_active = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_strobe", 64'(|{strobes(), nco_ftw_wr_en}), 64'd1);
            if (i == 0) chk("nco_sel", 64'(nco_ftw_wr_en), 64'h04);
            if (i == 0) chk("nco_bank_zero", 64'(bank_wr_sel), 64'h00);
            if (i == 1) chk("itab_sel", 64'(inst_table_wr_sel), 64'h80);
        end

        // Reset with entries queued and a strobe in flight
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        drive_active = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            set_cmd(i, 8'h02, 100 + i, 32'h5500 + i, 1'b0);
            step();
        end
        cmd_valid = 1'b0;
        drive_active = 1'b0;
        step();
        step();
        #3;
        rst = 1'b0;
        #1;
        check_all_zero("async_rst");
        q.delete();
        phase = 0; e_en = '0; e_bank = '0; e_itab = '0; e_nco = '0;
        e_addr = '0; e_data = '0; e_trig = 1'b0; e_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid  = ($urandom_range(0, 1) == 1);
            cmd_target = 3'($urandom_range(0, 7));
            cmd_sel    = ($urandom_range(0, 7) == 0) ? '0 : SW'(1 << $urandom_range(0, SW - 1));
            cmd_addr   = AW'($urandom);
            cmd_data   = DW'($urandom);
            cmd_last   = ($urandom_range(0, 3) == 0);
            run_req    = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 4) == 0) drive_active = ~drive_active;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
